non_restoring_division_param: RTL and testbench

Parametrised, multi-cycle non-restoring integer divider that supersedes the fixed 16-bit divider. It supports a per-operation signed/unsigned mode, flags divide-by-zero and signed overflow, and exposes a busy/done handshake. FSM control and the A/Q/M datapath are kept as separate units, matching the existing control-path/datapath split. It sits beside the arithmetic units and is driven by a start pulse from the system controller.

---
 rtl/non_restoring_division_pkg.sv | 23 ++
 rtl/non_restoring_division_param_dp.sv | 157 +++++++++++++++
 rtl/non_restoring_division_param.sv | 120 ++++++++++++
 tb/tb_non_restoring_division_param.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/non_restoring_division_pkg.sv
// Shared definitions for the parametrised non-restoring divider.
// Holds the FSM state encoding, the legal operand-width range and a
// helper used by the top level to reject illegal WIDTH values at elaboration.
package non_restoring_division_pkg;

    localparam int unsigned MIN_WIDTH = 4;
    localparam int unsigned MAX_WIDTH = 32;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ITER    = 3'd1,
        ST_CORRECT = 3'd2,
        ST_SIGNFIX = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // True when w is a supported operand width.
    function automatic logic width_ok(input int unsigned w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/non_restoring_division_param_dp.sv
// Datapath of the non-restoring divider: A/Q/M registers, add/sub step,
// iteration counter, sign latches and the registered results.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   load, step, fix, finish  control strobes from the FSM
//   signed_mode, dividend,
//   divisor                  operands, sampled on load
//   quotient, remainder,
//   div_by_zero, overflow    registered results, written on finish
//   count_done               last iteration step is in progress
//   a_negative               partial remainder A is negative
//   divisor_zero             divisor input is zero (decoded at capture)
module non_restoring_division_param_dp
    import non_restoring_division_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             finish,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             count_done,
    output logic             a_negative,
    output logic             divisor_zero
);

    localparam int unsigned AW = WIDTH + 1;

    logic [AW-1:0]    a_q,     a_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] m_q,     m_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q,    dz_d;
    logic             ovf_q,   ovf_d;
    logic [WIDTH-1:0] quotient_q,    quotient_d;
    logic [WIDTH-1:0] remainder_q,   remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q,    overflow_d;

    logic             dvd_neg, dvs_neg;
    logic [AW-1:0]    m_ext, a_shift, a_step, a_fix;

    // Operand decode and one non-restoring step.
    always_comb begin
        dvd_neg      = signed_mode & dividend[WIDTH-1];
        dvs_neg      = signed_mode & divisor[WIDTH-1];
        divisor_zero = (divisor == '0);
        m_ext        = {1'b0, m_q};
        a_shift      = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        // Sign of the old A selects subtract (A >= 0) or add-back (A < 0).
        a_step       = a_q[AW-1] ? (a_shift + m_ext) : (a_shift - m_ext);
        a_fix        = a_q + m_ext;
        count_done   = (cnt_q == CNT_W'(WIDTH - 1));
        a_negative   = a_q[AW-1];
    end

    // Next-state for the working registers and the result registers.
    always_comb begin
        a_d           = a_q;
        q_d           = q_q;
        m_d           = m_q;
        cnt_d         = cnt_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dz_d          = dz_q;
        ovf_d         = ovf_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        if (load) begin
            a_d     = '0;
            // A zero divisor keeps the raw dividend in Q so it can be
            // returned unmodified as the remainder.
            q_d     = (dvd_neg && !divisor_zero) ? (WIDTH'(0) - dividend) : dividend;
            m_d     = dvs_neg ? (WIDTH'(0) - divisor) : divisor;
            cnt_d   = '0;
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            dz_d    = divisor_zero;
            // MIN / -1 runs the normal flow; only the flag is decoded here.
            ovf_d   = signed_mode
                      && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                      && (divisor == '1);
        end else if (step) begin
            a_d   = a_step;
            q_d   = {q_q[WIDTH-2:0], ~a_step[AW-1]};
            cnt_d = cnt_q + CNT_W'(1);
        end else if (fix) begin
            a_d = a_fix;
        end

        if (finish) begin
            if (dz_q) begin
                quotient_d    = '1;
                remainder_d   = q_q;
                div_by_zero_d = 1'b1;
                overflow_d    = 1'b0;
            end else begin
                quotient_d    = q_neg_q ? (WIDTH'(0) - q_q) : q_q;
                remainder_d   = r_neg_q ? (WIDTH'(0) - a_q[WIDTH-1:0]) : a_q[WIDTH-1:0];
                div_by_zero_d = 1'b0;
                overflow_d    = ovf_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q           <= '0;
            q_q           <= '0;
            m_q           <= '0;
            cnt_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dz_q          <= 1'b0;
            ovf_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            a_q           <= a_d;
            q_q           <= q_d;
            m_q           <= m_d;
            cnt_q         <= cnt_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dz_q          <= dz_d;
            ovf_q         <= ovf_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: rtl/non_restoring_division_param.sv
// Parametrised multi-cycle non-restoring integer divider (signed/unsigned).
// Top level: control FSM plus busy/done decode; arithmetic lives in _dp.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              request, accepted in IDLE or DONE only
//   signed_mode        1 = two's-complement operands (captured with start)
//   dividend, divisor  operands (captured with start)
//   quotient,
//   remainder          registered results, held until the next completion
//   busy               high in ITER, CORRECT and SIGNFIX
//   done               one-cycle completion pulse
//   div_by_zero,
//   overflow           result flags, valid with done
module non_restoring_division_param
    import non_restoring_division_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    // Reject unsupported widths at elaboration.
    if (!width_ok(WIDTH)) begin : g_width_check
        $error("non_restoring_division_param: WIDTH must be in 4..32");
    end

    state_e state_q, state_d;
    logic   busy_q, done_q;
    logic   load, step, fix, finish;
    logic   count_done, a_negative, divisor_zero;

    // Next-state and datapath strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    load = 1'b1;
                    // A zero divisor skips the iterations but still passes
                    // through SIGNFIX, so DONE lands one edge after capture.
                    state_d = divisor_zero ? ST_SIGNFIX : ST_ITER;
                end
            end
            ST_ITER: begin
                step = 1'b1;
                if (count_done) begin
                    state_d = ST_CORRECT;
                end
            end
            ST_CORRECT: begin
                fix     = a_negative;
                state_d = ST_SIGNFIX;
            end
            ST_SIGNFIX: begin
                finish  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_ITER) || (state_d == ST_CORRECT)
                       || (state_d == ST_SIGNFIX);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    non_restoring_division_param_dp #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .step         (step),
        .fix          (fix),
        .finish       (finish),
        .signed_mode  (signed_mode),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .overflow     (overflow),
        .count_done   (count_done),
        .a_negative   (a_negative),
        .divisor_zero (divisor_zero)
    );

endmodule

// File: tb/tb_non_restoring_division_param.sv
// Self-checking bench for non_restoring_division_param (WIDTH=16 and WIDTH=8).
// Expected results come from a C-style truncating division model and are
// queued at issue time; monitors pop and compare them when done pulses.
module tb_non_restoring_division_param;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sm;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          k;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        start16, sm16;
    logic [15:0] dvd16, dvs16, quo16, rem16;
    logic        busy16, done16, dz16, ov16;

    logic        start8, sm8;
    logic [7:0]  dvd8, dvs8, quo8, rem8;
    logic        busy8, done8, dz8, ov8;

    int   tests_run;
    int   tests_failed;
    int   cyc;
    exp_t sb16[$];
    exp_t sb8[$];
    exp_t m16;
    exp_t m8;

    non_restoring_division_param #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .start       (start16),
        .signed_mode (sm16),
        .dividend    (dvd16),
        .divisor     (dvs16),
        .quotient    (quo16),
        .remainder   (rem16),
        .busy        (busy16),
        .done        (done16),
        .div_by_zero (dz16),
        .overflow    (ov16)
    );

    non_restoring_division_param #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_mode (sm8),
        .dividend    (dvd8),
        .divisor     (dvs8),
        .quotient    (quo8),
        .remainder   (rem8),
        .busy        (busy8),
        .done        (done8),
        .div_by_zero (dz8),
        .overflow    (ov8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: truncating division, remainder sign follows the dividend.
    function automatic exp_t model(input int w, input bit sm, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint sa, sb, q, r, mask;
        mask = (longint'(1) << w) - 1;
        e.a = a; e.b = b; e.sm = sm; e.dz = 1'b0; e.ov = 1'b0; e.k = 0;
        if (b == 32'd0) begin
            e.q   = 32'(mask);
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            if (sm) begin
                if (a[w-1]) sa = sa - (longint'(1) << w);
                if (b[w-1]) sb = sb - (longint'(1) << w);
            end
            q     = sa / sb;
            r     = sa % sb;
            e.q   = 32'(q & mask);
            e.r   = 32'(r & mask);
            e.ov  = sm && (sa == -(longint'(1) << (w - 1))) && (sb == -1);
            e.lat = w + 2;
        end
        return e;
    endfunction

    // Scoreboard monitor, WIDTH=16 instance.
    always @(posedge clk) begin
        #1;
        if (done16 === 1'b1) begin
            if (sb16.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL dut16_unexpected_done got quotient=%h remainder=%h", quo16, rem16);
            end else begin
                m16 = sb16.pop_front();
                tests_run++;
                if (quo16 !== m16.q[15:0]) begin
                    tests_failed++;
                    $display("FAIL dut16_quotient sm=%0b %h/%h got=%h exp=%h", m16.sm, m16.a[15:0], m16.b[15:0], quo16, m16.q[15:0]);
                end
                tests_run++;
                if (rem16 !== m16.r[15:0]) begin
                    tests_failed++;
                    $display("FAIL dut16_remainder sm=%0b %h/%h got=%h exp=%h", m16.sm, m16.a[15:0], m16.b[15:0], rem16, m16.r[15:0]);
                end
                tests_run++;
                if ({dz16, ov16} !== {m16.dz, m16.ov}) begin
                    tests_failed++;
                    $display("FAIL dut16_flags sm=%0b %h/%h got dz/ov=%b%b exp=%b%b", m16.sm, m16.a[15:0], m16.b[15:0], dz16, ov16, m16.dz, m16.ov);
                end
                tests_run++;
                if ((cyc - m16.k) != m16.lat) begin
                    tests_failed++;
                    $display("FAIL dut16_latency %h/%h got=%0d exp=%0d", m16.a[15:0], m16.b[15:0], cyc - m16.k, m16.lat);
                end
            end
        end
    end

    // Scoreboard monitor, WIDTH=8 instance.
    always @(posedge clk) begin
        #1;
        if (done8 === 1'b1) begin
            if (sb8.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL dut8_unexpected_done got quotient=%h remainder=%h", quo8, rem8);
            end else begin
                m8 = sb8.pop_front();
                tests_run++;
                if (quo8 !== m8.q[7:0]) begin
                    tests_failed++;
                    $display("FAIL dut8_quotient sm=%0b %h/%h got=%h exp=%h", m8.sm, m8.a[7:0], m8.b[7:0], quo8, m8.q[7:0]);
                end
                tests_run++;
                if (rem8 !== m8.r[7:0]) begin
                    tests_failed++;
                    $display("FAIL dut8_remainder sm=%0b %h/%h got=%h exp=%h", m8.sm, m8.a[7:0], m8.b[7:0], rem8, m8.r[7:0]);
                end
                tests_run++;
                if ({dz8, ov8} !== {m8.dz, m8.ov}) begin
                    tests_failed++;
                    $display("FAIL dut8_flags sm=%0b %h/%h got dz/ov=%b%b exp=%b%b", m8.sm, m8.a[7:0], m8.b[7:0], dz8, ov8, m8.dz, m8.ov);
                end
                tests_run++;
                if ((cyc - m8.k) != m8.lat) begin
                    tests_failed++;
                    $display("FAIL dut8_latency %h/%h got=%0d exp=%0d", m8.a[7:0], m8.b[7:0], cyc - m8.k, m8.lat);
                end
            end
        end
    end

    // Drive a one-cycle start and queue the expected result; call #1 after an edge.
    task automatic issue16(input bit sm, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e   = model(16, sm, 32'(a), 32'(b));
        e.k = cyc + 1;
        sb16.push_back(e);
        sm16 = sm; dvd16 = a; dvs16 = b; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic issue8(input bit sm, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e   = model(8, sm, 32'(a), 32'(b));
        e.k = cyc + 1;
        sb8.push_back(e);
        sm8 = sm; dvd8 = a; dvs8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic drain16(output bit ok);
        int n;
        n = 0;
        while (sb16.size() != 0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (sb16.size() == 0);
    endtask

    task automatic drain8(output bit ok);
        int n;
        n = 0;
        while (sb8.size() != 0 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (sb8.size() == 0);
    endtask

    task automatic test_reset();
        tests_run++;
        if ({quo16, rem16, busy16, done16, dz16, ov16} !== 36'd0) begin
            tests_failed++;
            $display("FAIL reset_dut16 got=%h exp=0", {quo16, rem16, busy16, done16, dz16, ov16});
        end
        tests_run++;
        if ({quo8, rem8, busy8, done8, dz8, ov8} !== 20'd0) begin
            tests_failed++;
            $display("FAIL reset_dut8 got=%h exp=0", {quo8, rem8, busy8, done8, dz8, ov8});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic16();
        bit ok;
        issue16(1'b0, 16'd100, 16'd7);
        tests_run++;
        if (busy16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_after_start got=%b exp=1", busy16);
        end
        drain16(ok);
        issue16(1'b1, 16'hFF9C, 16'h0007);
        drain16(ok);
        issue16(1'b1, 16'h0007, 16'hFFFE);
        drain16(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL basic16_timeout pending=%0d exp=0", sb16.size());
        end
    endtask

    task automatic test_div_zero();
        bit ok;
        issue16(1'b0, 16'd1234, 16'd0);
        drain16(ok);
        issue16(1'b1, 16'd1234, 16'd0);
        drain16(ok);
        issue8(1'b1, 8'h85, 8'h00);
        drain8(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL div_zero_timeout pending=%0d exp=0", sb8.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        issue16(1'b1, 16'h8000, 16'hFFFF);
        drain16(ok);
        issue16(1'b0, 16'h8000, 16'hFFFF);
        drain16(ok);
        issue8(1'b1, 8'h80, 8'hFF);
        drain8(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL overflow_timeout pending=%0d exp=0", sb8.size());
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        issue16(1'b0, 16'd1000, 16'd3);
        sm16 = 1'b1; dvd16 = 16'd5; dvs16 = 16'd1; start16 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (busy16 !== 1'b1) begin
                tests_failed++;
                $display("FAIL busy_hold cycle=%0d got=%b exp=1", i, busy16);
            end
            @(posedge clk); #1;
        end
        start16 = 1'b0;
        drain16(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL busy_ignore_timeout pending=%0d exp=0", sb16.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        issue16(1'b0, 16'd50000, 16'd123);
        n = 0;
        while (done16 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (done16 !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_done got=%b exp=1", done16);
        end
        // Start in the DONE cycle itself.
        issue16(1'b1, 16'hFED4, 16'd11);
        tests_run++;
        if ({done16, busy16} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_no_bubble got done/busy=%b%b exp=01", done16, busy16);
        end
        drain16(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL b2b_timeout pending=%0d exp=0", sb16.size());
        end
    endtask

    task automatic test_abort();
        bit ok;
        int n_done;
        issue16(1'b0, 16'd40000, 16'd7);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({quo16, rem16, busy16, done16, dz16, ov16} !== 36'd0) begin
            tests_failed++;
            $display("FAIL abort_outputs got=%h exp=0", {quo16, rem16, busy16, done16, dz16, ov16});
        end
        sb16.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done16 === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done got=%0d exp=0", n_done);
        end
        issue16(1'b0, 16'd100, 16'd7);
        drain16(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL abort_recover_timeout pending=%0d exp=0", sb16.size());
        end
    endtask

    task automatic test_width8();
        bit ok;
        logic [7:0] a, b;
        bit sm;
        issue8(1'b0, 8'd255, 8'd16);
        drain8(ok);
        for (int i = 0; i < 60; i++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            issue8(sm, a, b);
            drain8(ok);
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL width8_timeout pending=%0d exp=0", sb8.size());
        end
    endtask

    task automatic test_random16();
        bit ok;
        for (int i = 0; i < 16; i++) begin
            issue16(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(1, 400)));
            drain16(ok);
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL random16_timeout pending=%0d exp=0", sb16.size());
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b0;
        start16 = 1'b0; sm16 = 1'b0; dvd16 = '0; dvs16 = '0;
        start8  = 1'b0; sm8  = 1'b0; dvd8  = '0; dvs8  = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic16();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        test_width8();
        test_random16();
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
